// File: rtl/alu_seq_pkg.sv
// Shared opcodes, state encoding and default width for the ALU operation sequencer.
package alu_seq_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_ADD = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_MOD = 3'b111;

   localparam logic [1:0] ENC_IDLE     = 2'd0;
   localparam logic [1:0] ENC_EXEC     = 2'd1;
   localparam logic [1:0] ENC_MOD_ITER = 2'd2;
   localparam logic [1:0] ENC_RESP     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = ENC_IDLE,
      ST_EXEC     = ENC_EXEC,
      ST_MOD_ITER = ENC_MOD_ITER,
      ST_RESP     = ENC_RESP
   } state_t;

endpackage

// File: rtl/alu_seq_iter_cnt.sv
// Loadable iteration up-counter for MOD sequencing; o_term flags the iteration
// whose increment brings the count to MAX_ITER.
module alu_seq_iter_cnt #(
   parameter int MAX_ITER = 255,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_inc,
   output logic             o_term
);

   localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_ITER - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_term = (r_cnt == TERM_VAL);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle request/response controller in front of the combinational ALU.
// Optional performance counters are built when ALU_SEQ_PERF_EN is defined.
//
//   state    | meaning
//   IDLE     | waiting for a request, req_ready high
//   EXEC     | single-cycle ALU op in flight, result captured next edge
//   MOD_ITER | repeated subtraction r - b until r < b or iteration limit
//   RESP     | rsp_valid high, data/err held until rsp_ready
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int MOD_MAX_ITER = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [2:0]       alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_mod_cycles
`endif
);

   localparam int CNT_W = $clog2(MOD_MAX_ITER + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_alu_sel;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_err;

   logic w_accept;
   logic w_is_mod;
   logic w_mod_zero;
   logic w_mod_short;
   logic w_iter_done;
   logic w_iter_term;
   logic w_in_iter;
   logic w_rsp_hs;

   assign w_accept    = (r_state == ST_IDLE) && req_valid;
   assign w_is_mod    = (req_op == OP_MOD);
   assign w_mod_zero  = (req_b == '0);
   assign w_mod_short = (req_a < req_b);
   assign w_in_iter   = (r_state == ST_MOD_ITER);
   assign w_iter_done = (alu_result < r_alu_b);
   assign w_rsp_hs    = (r_state == ST_RESP) && rsp_ready;

   alu_seq_iter_cnt #(
      .MAX_ITER (MOD_MAX_ITER),
      .CNT_W    (CNT_W)
   ) u_iter_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept && w_is_mod),
      .i_load_val ('0),
      .i_inc      (w_in_iter),
      .o_term     (w_iter_term)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               if (!w_is_mod) begin
                  w_state_nxt = ST_EXEC;
               end else if (w_mod_zero || w_mod_short) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_MOD_ITER;
               end
            end
         end
         ST_EXEC: begin
            w_state_nxt = ST_RESP;
         end
         ST_MOD_ITER: begin
            if (w_iter_done || w_iter_term) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // r_alu_a doubles as the running remainder while in MOD_ITER.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_sel  <= OP_AND;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_alu_sel <= w_is_mod ? OP_SUB : req_op;
                  r_alu_a   <= req_a;
                  r_alu_b   <= req_b;
                  if (w_is_mod && w_mod_zero) begin
                     r_rsp_data <= '0;
                     r_rsp_err  <= 1'b1;
                  end else if (w_is_mod && w_mod_short) begin
                     r_rsp_data <= req_a;
                     r_rsp_err  <= 1'b0;
                  end
               end
            end
            ST_EXEC: begin
               r_rsp_data <= alu_result;
               r_rsp_err  <= 1'b0;
            end
            ST_MOD_ITER: begin
               if (w_iter_done) begin
                  r_rsp_data <= alu_result;
                  r_rsp_err  <= 1'b0;
               end else if (w_iter_term) begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_alu_a <= alu_result;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign alu_sel  = r_alu_sel;
   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign rsp_data = r_rsp_data;
   assign rsp_err  = r_rsp_err;

`ifdef ALU_SEQ_PERF_EN
   logic [31:0] r_perf_ops;
   logic [31:0] r_perf_mod_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_ops        <= '0;
         r_perf_mod_cycles <= '0;
      end else begin
         if (w_rsp_hs && (r_perf_ops != '1)) begin
            r_perf_ops <= r_perf_ops + 32'd1;
         end
         if (w_in_iter && (r_perf_mod_cycles != '1)) begin
            r_perf_mod_cycles <= r_perf_mod_cycles + 32'd1;
         end
      end
   end

   assign perf_ops        = r_perf_ops;
   assign perf_mod_cycles = r_perf_mod_cycles;
`else
   logic w_unused_hs;
   assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_op_sequencer;

   localparam int MAXI = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [2:0]  alu_sel;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;
`ifdef ALU_SEQ_PERF_EN
   logic [31:0] perf_ops;
   logic [31:0] perf_mod_cycles;
`endif

   int checks = 0;
   int failures = 0;
   int exp_ops = 0;
   int exp_mod_cyc = 0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_sel    (alu_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy)
`ifdef ALU_SEQ_PERF_EN
      ,
      .perf_ops        (perf_ops),
      .perf_mod_cycles (perf_mod_cycles)
`endif
   );

   // The external combinational ALU the sequencer drives.
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         3'd0: alu_result = alu_a & alu_b;
         3'd1: alu_result = alu_a | alu_b;
         3'd2: alu_result = alu_a ^ alu_b;
         3'd3: alu_result = ~(alu_a | alu_b);
         3'd4: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         3'd5: alu_result = alu_a + alu_b;
         3'd6: alu_result = alu_a - alu_b;
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic e,
                                 output int lat, output int iters);
      logic [31:0] q;
      e = 1'b0;
      iters = 0;
      lat = 2;
      d = '0;
      case (op)
         3'd0: d = a & b;
         3'd1: d = a | b;
         3'd2: d = a ^ b;
         3'd3: d = ~(a | b);
         3'd4: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd5: d = a + b;
         3'd6: d = a - b;
         default: begin
            if (b == 0) begin
               e = 1'b1;
               lat = 1;
            end else begin
               q = a / b;
               if (q > 32'(MAXI)) begin
                  iters = MAXI;
                  e = 1'b1;
               end else begin
                  iters = int'(q);
                  d = a % b;
               end
               lat = 1 + iters;
            end
         end
      endcase
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] exp_d;
      logic        exp_e;
      int          exp_lat;
      int          iters;
      int          n;
      int          lat;
      logic [31:0] k;
      model(op, a, b, exp_d, exp_e, exp_lat, iters);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      chk("alu_sel_first", {29'd0, alu_sel}, (op == 3'd7) ? 32'd6 : {29'd0, op});
      chk("alu_b_first", alu_b, b);
      while (!rsp_valid && lat < 300) begin
         if (op == 3'd7 && lat <= iters && lat <= 3) begin
            k = 32'(lat - 1);
            chk("mod_alu_a", alu_a, a - k * b);
         end
         chk("busy_inflight", {31'd0, busy}, 32'd1);
         @(negedge clk);
         lat++;
      end
      chk("rsp_latency", 32'(lat), 32'(exp_lat));
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_data", rsp_data, exp_d);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
      exp_ops++;
      exp_mod_cyc += iters;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_data"}, rsp_data, 32'd0);
      chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
      chk({tag, "_alu_sel"}, {29'd0, alu_sel}, 32'd0);
      chk({tag, "_alu_a"}, alu_a, 32'd0);
      chk({tag, "_alu_b"}, alu_b, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3'd5, 32'd5, 32'd7, 0);
      run_op(3'd7, 32'd17, 32'd5, 0);
      run_op(3'd7, 32'd3, 32'd9, 1);
      run_op(3'd7, 32'd10, 32'd0, 0);
      run_op(3'd7, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(3'd7, 32'd765, 32'd3, 0);
      run_op(3'd7, 32'd768, 32'd3, 0);
      run_op(3'd7, 32'd9, 32'd9, 0);
      run_op(3'd2, 32'h0000_F0F0, 32'h0000_0FF0, 5);
      run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(3'd3, 32'h1234_0000, 32'h0000_5678, 2);

      // Abort a MOD mid-iteration; nothing of it may survive.
      req_valid = 1'b1;
      req_op = 3'd7;
      req_a = 32'd100;
      req_b = 32'd3;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_ops = 0;
      exp_mod_cyc = 0;
      @(negedge clk);
      run_op(3'd6, 32'd9, 32'd4, 0);

      for (int i = 0; i < 25; i++) begin
         op = 3'($urandom_range(0, 7));
         if (op == 3'd7) begin
            b = 32'($urandom_range(0, 20));
            a = (b == 0) ? $urandom : b * 32'($urandom_range(0, 280)) + 32'($urandom_range(0, 32'(b) - 1));
         end else begin
            a = $urandom;
            b = $urandom;
         end
         run_op(op, a, b, $urandom_range(0, 3));
      end

`ifdef ALU_SEQ_PERF_EN
      chk("perf_ops", perf_ops, 32'(exp_ops));
      chk("perf_mod_cycles", perf_mod_cycles, 32'(exp_mod_cyc));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller in front of the 32-bit combinational ALU and its 8:1 result-select mux. Accepts one operation request at a time over a valid/ready handshake and drives the ALU operands and 3-bit select. Captures the result and returns it over a second valid/ready handshake. AND/OR/XOR/NOR/SLT/ADD/SUB take one ALU cycle; MOD is sequenced as repeated ALU subtractions.

Parameters:
WIDTH, 32, operand/result width
MOD_MAX_ITER, 255, maximum MOD subtraction iterations before abort with error

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request (high only in IDLE)
req_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
alu_sel  output  3  select to ALU result mux
alu_a  output  WIDTH  ALU operand A
alu_b  output  WIDTH  ALU operand B
alu_result  input  WIDTH  combinational ALU result for current alu_sel/alu_a/alu_b
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  WIDTH  result
rsp_err  output  1  MOD by zero or MOD_MAX_ITER exceeded; rsp_data = 0 when set
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-safe deassert on next clk edge): state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; alu_sel=000; alu_a=0; alu_b=0; busy=0; iteration counter 0.
- States: IDLE, EXEC, MOD_ITER, RESP.
- IDLE: on req_valid&&req_ready, latch op/a/b; drive alu_sel=req_op (MOD: alu_sel=110), alu_a=a, alu_b=b. Non-MOD -> EXEC. MOD with b==0 -> RESP with rsp_err=1, rsp_data=0. MOD with a<b (unsigned) -> RESP with rsp_data=a. Otherwise MOD -> MOD_ITER with remainder r=a, count=0.
- EXEC: one cycle; capture alu_result into rsp_data, rsp_err=0 -> RESP. Request-accept to rsp_valid latency is 2 cycles.
- MOD_ITER: alu_sel=110, alu_a=r, alu_b=b each cycle. On clk: r<=alu_result, count<=count+1. Exit when new r < b (unsigned internal compare on alu_result): rsp_data=new r -> RESP. If count reaches MOD_MAX_ITER without exit: rsp_err=1, rsp_data=0 -> RESP. Operands are unsigned for MOD; SLT semantics are owned by the ALU.
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_valid&&rsp_ready. On handshake -> IDLE, rsp_valid=0. A new request is not accepted in the same cycle; the earliest next accept is the following cycle.
- req_ready=1 only in IDLE. Requests presented while busy are held by the requester and not dropped.
- alu_* outputs keep their last value in IDLE/RESP. They are don't-care for the ALU but must be deterministic.
- rst_n asserted mid-operation aborts immediately to reset values. No response is generated for the aborted request.

Optional Feature:
ALU_SEQ_PERF_EN: when defined, adds outputs perf_ops (32b, count of completed rsp handshakes) and perf_mod_cycles (32b, total cycles spent in MOD_ITER). Both reset to 0 and saturate at all-ones. When undefined, these ports and counters do not exist.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_AND..OP_MOD, values above), state encoding localparams (IDLE=0, EXEC=1, MOD_ITER=2, RESP=3), WIDTH default.
- One sub-module: alu_seq_iter_cnt. It is a loadable up-counter with a terminal flag at MOD_MAX_ITER, used by MOD_ITER. Everything else stays in the top.

Test Plan:
- ADD a=5, b=7, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=12, rsp_err=0, alu_sel=101 during EXEC.
- MOD a=17, b=5 -> 3 MOD_ITER cycles (alu_a 17,12,7), rsp_data=2, rsp_err=0; MOD a=3, b=9 -> rsp_data=3 without entering MOD_ITER.
- MOD a=10, b=0 -> RESP next cycle, rsp_err=1, rsp_data=0; MOD a=0xFFFFFFFF, b=1 with MOD_MAX_ITER=255 -> rsp_err=1 after 255 iterations.
- Backpressure: XOR a=0xF0F0, b=0x0FF0, rsp_ready low 5 cycles -> rsp_valid held, rsp_data=0xFF00 stable, req_ready=0 throughout.
- Reset during MOD_ITER (a=100, b=3) -> all outputs at reset values immediately; next SUB a=9, b=4 returns 5.
- With ALU_SEQ_PERF_EN: ADD then MOD 17%5 -> perf_ops=2, perf_mod_cycles=3.
